// File: rtl/dump_stage.sv
// Squeeze output stage: accepts rate-sized blocks from the permutation and streams them out as
// w-bit words until the requested number of output bits has been delivered.
module dump_stage #(
  parameter int unsigned w             = 64,
  parameter int unsigned RATE_SHAKE128 = 1344,
  parameter int unsigned RATE_SHAKE256 = 1088
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RATE_SHAKE128-1:0] block_in,
  input  logic [31:0]              output_size,
  input  logic [1:0]               operation_mode,
  input  logic                     block_valid_in,
  output logic                     block_ready_out,
  output logic                     squeeze_more_out,
  output logic [w-1:0]             data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     last_out
);

  localparam int unsigned Words128 = RATE_SHAKE128 / w;
  localparam int unsigned Words256 = RATE_SHAKE256 / w;
  localparam int unsigned IdxW     = $clog2(Words128 + 1);

  localparam logic [IdxW-1:0] LastIdx128 = IdxW'(Words128 - 1);
  localparam logic [IdxW-1:0] LastIdx256 = IdxW'(Words256 - 1);
  localparam logic [31:0]     WordBits   = 32'(w);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitBlock
  } state_e;

  state_e                   state_q, state_d;
  logic [RATE_SHAKE128-1:0] shift_q, shift_d;
  logic [31:0]              remaining_q, remaining_d;
  logic                     shake256_q, shake256_d;
  logic [IdxW-1:0]          word_idx_q, word_idx_d;

  logic                     block_xfer;
  logic                     word_xfer;
  logic                     last_in_block;
  logic [w-1:0]             word_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      remaining_q <= '0;
      shake256_q  <= 1'b0;
      word_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      shake256_q  <= shake256_d;
      word_idx_q  <= word_idx_d;
    end
  end

  // Outputs are pure functions of the registered state, so they hold across stalls.
  always_comb begin
    block_ready_out  = (state_q != StSend);
    squeeze_more_out = (state_q == StWaitBlock);
    valid_out        = (state_q == StSend);
    last_out         = valid_out && (remaining_q <= WordBits);

    // Only the low 'remaining' bits of a partial final word are meaningful.
    if (remaining_q < WordBits) begin
      word_mask = ({{(w-1){1'b0}}, 1'b1} << remaining_q) - {{(w-1){1'b0}}, 1'b1};
    end else begin
      word_mask = '1;
    end
    data_out = shift_q[w-1:0] & word_mask;
  end

  always_comb begin
    block_xfer    = block_valid_in && block_ready_out;
    word_xfer     = valid_out && ready_in;
    last_in_block = (word_idx_q == (shake256_q ? LastIdx256 : LastIdx128));

    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    shake256_d  = shake256_q;
    word_idx_d  = word_idx_q;

    unique case (state_q)
      StIdle: begin
        if (block_xfer) begin
          shift_d     = block_in;
          remaining_d = output_size;
          shake256_d  = (operation_mode != 2'b00);
          word_idx_d  = '0;
          // A zero-length request swallows the block without emitting anything.
          state_d     = (output_size == 32'd0) ? StIdle : StSend;
        end
      end

      StSend: begin
        if (word_xfer) begin
          shift_d     = shift_q >> w;
          word_idx_d  = word_idx_q + 1'b1;
          remaining_d = remaining_q - ((remaining_q > WordBits) ? WordBits : remaining_q);
          if (last_out) begin
            state_d = StIdle;
          end else if (last_in_block) begin
            state_d = StWaitBlock;
          end
        end
      end

      StWaitBlock: begin
        // Continuation block: request length and rate stay as latched at the start.
        if (block_xfer) begin
          shift_d    = block_in;
          word_idx_d = '0;
          state_d    = StSend;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule
